banked_register_file: RTL

//  Per-core register file holding NUM_THREADS independent banks of NUM_REGS x DATA_W registers.

---
 rtl/minigpu_pkg.sv | 28 ++
 rtl/banked_register_file_if.sv | 26 ++
 rtl/rf_scoreboard.sv | 50 +++++
 rtl/banked_register_file.sv | 133 +++++++++++++
 4 files changed

// File: rtl/minigpu_pkg.sv
// Shared encodings for the banked register file.
// Scheduler states and reserved-register offsets.
package minigpu_pkg;

   typedef enum logic [2:0] {
      STATE_IDLE    = 3'b000,
      STATE_FETCH   = 3'b001,
      STATE_DECODE  = 3'b010,
      STATE_REQUEST = 3'b011,
      STATE_WAIT    = 3'b100,
      STATE_EXECUTE = 3'b101,
      STATE_UPDATE  = 3'b110,
      STATE_DONE    = 3'b111
   } core_state_t;

   // Offsets counted down from NUM_REGS
   localparam int RSV_BLOCK_ID  = 3;
   localparam int RSV_THREAD_ID = 2;
   localparam int RSV_TPB       = 1;

   function automatic logic is_reserved(
      input int unsigned addr,
      input int unsigned num_regs
   );
      return addr >= (num_regs - 32'(RSV_BLOCK_ID));
   endfunction

endpackage

// File: rtl/banked_register_file_if.sv
// LSU write-back handshake bundle.
// Master is the LSU, slave is the register file.
interface banked_register_file_if #(
   parameter int NUM_THREADS = 4,
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 4
);
   logic [NUM_THREADS-1:0]        lsu_wb_valid;
   logic [ADDR_W-1:0]             lsu_wb_addr;
   logic [NUM_THREADS*DATA_W-1:0] lsu_wb_data;
   logic                          lsu_wb_ready;

   modport master (
      output lsu_wb_valid,
      output lsu_wb_addr,
      output lsu_wb_data,
      input  lsu_wb_ready
   );

   modport slave (
      input  lsu_wb_valid,
      input  lsu_wb_addr,
      input  lsu_wb_data,
      output lsu_wb_ready
   );
endinterface

// File: rtl/rf_scoreboard.sv
// Per-thread load scoreboard: pending bits and hazard.
// Set beats clear when both target the same bit.
module rf_scoreboard #(
   parameter int NUM_REGS    = 16,
   parameter int NUM_THREADS = 4,
   parameter int ADDR_W      = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_THREADS-1:0] set,
   input  logic [NUM_THREADS-1:0] clr,
   input  logic [ADDR_W-1:0]      clr_addr,
   input  logic [NUM_THREADS-1:0] thread_en,
   input  logic [ADDR_W-1:0]      rs_addr,
   input  logic [ADDR_W-1:0]      rt_addr,
   input  logic [ADDR_W-1:0]      rd_addr,
   output logic                   hazard,
   output logic [NUM_THREADS-1:0] rd_pend
);

   logic [NUM_REGS-1:0] pend [NUM_THREADS];

   // Pending-bit update; set is applied last so it wins
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int t = 0; t < NUM_THREADS; t++)
            pend[t] <= '0;
      end else begin
         for (int t = 0; t < NUM_THREADS; t++) begin
            if (clr[t])
               pend[t][clr_addr] <= 1'b0;
            if (set[t])
               pend[t][rd_addr] <= 1'b1;
         end
      end
   end

   // Hazard reduction over active threads
   always_comb begin
      hazard  = 1'b0;
      rd_pend = '0;
      for (int t = 0; t < NUM_THREADS; t++) begin
         rd_pend[t] = pend[t][rd_addr];
         if (thread_en[t])
            hazard = hazard | pend[t][rs_addr]
                   | pend[t][rt_addr] | pend[t][rd_addr];
      end
   end

endmodule

// File: rtl/banked_register_file.sv
// Banked per-thread register file with LSU write-back port.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writes to reads.
module banked_register_file
   import minigpu_pkg::*;
#(
   parameter  int DATA_W      = 8,
   parameter  int NUM_REGS    = 16,
   parameter  int NUM_THREADS = 4,
   localparam int ADDR_W      = $clog2(NUM_REGS)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic [2:0]                    core_state,
   input  logic [NUM_THREADS-1:0]        thread_en,
   input  logic                          ctx_load,
   input  logic [DATA_W-1:0]             block_id,
   input  logic [DATA_W-1:0]             threads_per_block,
   input  logic [ADDR_W-1:0]             rs_addr,
   input  logic [ADDR_W-1:0]             rt_addr,
   input  logic [ADDR_W-1:0]             rd_addr,
   input  logic                          wr_en,
   input  logic [NUM_THREADS*DATA_W-1:0] wr_data,
   input  logic                          ld_issue,
   banked_register_file_if.slave         lsu_wb,
   output logic [NUM_THREADS*DATA_W-1:0] rs_data,
   output logic [NUM_THREADS*DATA_W-1:0] rt_data,
   output logic                          hazard,
   output logic                          wr_conflict_err
);

   logic [DATA_W-1:0]      regs [NUM_THREADS][NUM_REGS];
   logic                   req;
   logic                   rd_rsv;
   logic                   wb_rsv;
   logic                   wb_block;
   logic [NUM_THREADS-1:0] core_try;
   logic [NUM_THREADS-1:0] core_we;
   logic [NUM_THREADS-1:0] conflict;
   logic [NUM_THREADS-1:0] ld_set;
   logic [NUM_THREADS-1:0] wb_we;
   logic [NUM_THREADS-1:0] rd_pend;

   // Write qualification; core write wins an address clash with the LSU
   always_comb begin
      req      = enable && (core_state == STATE_REQUEST);
      rd_rsv   = is_reserved(32'(rd_addr), NUM_REGS);
      wb_rsv   = is_reserved(32'(lsu_wb.lsu_wb_addr), NUM_REGS);
      core_try = (req && wr_en && !rd_rsv) ? thread_en : '0;
      core_we  = core_try & ~rd_pend;
      conflict = core_try & rd_pend;
      ld_set   = (req && ld_issue && !rd_rsv) ? thread_en : '0;
      wb_block = (lsu_wb.lsu_wb_addr == rd_addr)
               && |(core_we & lsu_wb.lsu_wb_valid);
      wb_we    = (enable && !wb_block && !wb_rsv)
               ? lsu_wb.lsu_wb_valid : '0;
   end

   assign lsu_wb.lsu_wb_ready = !wb_block;

   rf_scoreboard #(
      .NUM_REGS    (NUM_REGS),
      .NUM_THREADS (NUM_THREADS),
      .ADDR_W      (ADDR_W)
   ) u_sb (
      .clk       (clk),
      .reset     (reset),
      .set       (ld_set),
      .clr       (wb_we),
      .clr_addr  (lsu_wb.lsu_wb_addr),
      .thread_en (thread_en),
      .rs_addr   (rs_addr),
      .rt_addr   (rt_addr),
      .rd_addr   (rd_addr),
      .hazard    (hazard),
      .rd_pend   (rd_pend)
   );

   // Register array: reset image, context load, then data writes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int t = 0; t < NUM_THREADS; t++)
            for (int r = 0; r < NUM_REGS; r++)
               regs[t][r] <= (r == NUM_REGS - RSV_THREAD_ID)
                           ? DATA_W'(t) : '0;
      end else begin
         if (enable && ctx_load) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
               regs[t][NUM_REGS-RSV_BLOCK_ID] <= block_id;
               regs[t][NUM_REGS-RSV_TPB]      <= threads_per_block;
            end
         end
         for (int t = 0; t < NUM_THREADS; t++) begin
            if (wb_we[t])
               regs[t][lsu_wb.lsu_wb_addr] <=
                  lsu_wb.lsu_wb_data[t*DATA_W +: DATA_W];
            else if (core_we[t])
               regs[t][rd_addr] <= wr_data[t*DATA_W +: DATA_W];
         end
      end
   end

   // Sticky flag for core writes dropped on a pending register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         wr_conflict_err <= 1'b0;
      else if (|conflict)
         wr_conflict_err <= 1'b1;
   end

   // Combinational read ports, optionally forwarding this cycle's commit
   always_comb begin
      rs_data = '0;
      rt_data = '0;
      for (int t = 0; t < NUM_THREADS; t++) begin
         rs_data[t*DATA_W +: DATA_W] = regs[t][rs_addr];
         rt_data[t*DATA_W +: DATA_W] = regs[t][rt_addr];
`ifdef REGFILE_BYPASS_EN
         if (core_we[t] && rd_addr == rs_addr)
            rs_data[t*DATA_W +: DATA_W] = wr_data[t*DATA_W +: DATA_W];
         if (core_we[t] && rd_addr == rt_addr)
            rt_data[t*DATA_W +: DATA_W] = wr_data[t*DATA_W +: DATA_W];
         if (wb_we[t] && lsu_wb.lsu_wb_addr == rs_addr)
            rs_data[t*DATA_W +: DATA_W] =
               lsu_wb.lsu_wb_data[t*DATA_W +: DATA_W];
         if (wb_we[t] && lsu_wb.lsu_wb_addr == rt_addr)
            rt_data[t*DATA_W +: DATA_W] =
               lsu_wb.lsu_wb_data[t*DATA_W +: DATA_W];
`endif
      end
   end

endmodule
